// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates fetch and load/store clients onto a byte-wide RAM port, serialising each request little-endian.
// Optional MC_IO_STALL_EN: stall writes into the IO window (addr[17:16]==2'b11) while io_buffer_full is set.
module mem_ctrl #(
    parameter int IF_BLK_BYTES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic [7:0]                mem_din,
    output logic [7:0]                mem_dout,
    output logic [31:0]               mem_a,
    output logic                      mem_wr,
    input  logic                      io_buffer_full,
    input  logic                      if_en,
    input  logic [31:0]               if_pc,
    output logic                      if_done,
    output logic [IF_BLK_BYTES*8-1:0] if_data,
    input  logic                      lsb_en,
    input  logic                      lsb_wr,
    input  logic [31:0]               lsb_addr,
    input  logic [2:0]                lsb_len,
    input  logic [31:0]               lsb_w_data,
    output logic                      lsb_done,
    output logic [31:0]               lsb_r_data,
    input  logic                      rob_clear
);
    typedef enum logic [2:0] {IDLE, IF_READ, LSB_READ, LSB_WRITE, DONE} state_t;
    state_t state;
    logic [6:0] cnt, len, cnt_n;
    logic [31:0] base, a_q, wdata;
    logic [7:0] dout_q;
    logic pend, wr_q, last_if, stall, step, lsb_ok, pick_lsb, reading;

`ifdef MC_IO_STALL_EN
    assign stall = state == LSB_WRITE && base[17:16] == 2'b11 && io_buffer_full;
`else
    assign stall = 1'b0 & io_buffer_full;
`endif

    assign mem_a = stall ? '0 : a_q;
    assign mem_wr = wr_q & rdy & ~stall;
    assign mem_dout = stall ? '0 : dout_q;
    assign reading = state == IF_READ || state == LSB_READ;
    // pend marks a read address issued last cycle, so mem_din holds its byte now
    assign step = reading ? pend : wr_q & ~stall;
    assign cnt_n = cnt + {6'b0, step};
    assign lsb_ok = lsb_en & (lsb_wr | ~rob_clear);
    assign pick_lsb = lsb_ok & (~if_en | last_if);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            len <= '0;
            base <= '0;
            a_q <= '0;
            wdata <= '0;
            dout_q <= '0;
            pend <= 1'b0;
            wr_q <= 1'b0;
            last_if <= 1'b1;
            if_done <= 1'b0;
            lsb_done <= 1'b0;
            if_data <= '0;
            lsb_r_data <= '0;
        end else begin
            if_done <= 1'b0;
            lsb_done <= 1'b0;
            if (state == LSB_READ && rob_clear) begin
                state <= IDLE;
                a_q <= '0;
                pend <= 1'b0;
            end else if (state == DONE) begin
                state <= IDLE;
            end else if (rdy) begin
                case (state)
                    IDLE: begin
                        if (pick_lsb) begin
                            base <= lsb_addr;
                            a_q <= lsb_addr;
                            len <= {4'b0, lsb_len};
                            wdata <= lsb_w_data;
                            cnt <= '0;
                            pend <= 1'b0;
                            last_if <= 1'b0;
                            wr_q <= lsb_wr;
                            dout_q <= lsb_wr ? lsb_w_data[7:0] : '0;
                            state <= lsb_wr ? LSB_WRITE : LSB_READ;
                            if (!lsb_wr) lsb_r_data <= '0;
                        end else if (if_en) begin
                            base <= if_pc;
                            a_q <= if_pc;
                            len <= 7'(IF_BLK_BYTES);
                            cnt <= '0;
                            pend <= 1'b0;
                            last_if <= 1'b1;
                            state <= IF_READ;
                        end
                    end
                    IF_READ, LSB_READ: begin
                        if (pend) begin
                            if (state == IF_READ) if_data[{cnt, 3'b0} +: 8] <= mem_din;
                            else lsb_r_data[{cnt[1:0], 3'b0} +: 8] <= mem_din;
                        end
                        cnt <= cnt_n;
                        pend <= cnt_n < len;
                        a_q <= cnt_n + 7'd1 < len ? base + 32'(cnt_n) + 32'd1 : '0;
                        if (cnt_n == len) begin
                            state <= DONE;
                            if_done <= state == IF_READ;
                            lsb_done <= state == LSB_READ;
                        end
                    end
                    LSB_WRITE: begin
                        cnt <= cnt_n;
                        if (cnt_n == len) begin
                            state <= DONE;
                            lsb_done <= 1'b1;
                            wr_q <= 1'b0;
                            a_q <= '0;
                            dout_q <= '0;
                        end else begin
                            a_q <= base + 32'(cnt_n);
                            wr_q <= 1'b1;
                            dout_q <= wdata[{cnt_n[1:0], 3'b0} +: 8];
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (reading) begin
                // a byte in flight when rdy dropped is refetched once rdy returns
                a_q <= base + 32'(cnt);
                pend <= 1'b0;
            end
        end
    end
endmodule
